fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, instruction queue entries (power of two, 2..16).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: imem_req  out  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  out  32  fetch address, word-aligned (bits [1:0] = 0).
REQ-007 Port: imem_gnt  in  1  request accepted this cycle.
REQ-008 Port: imem_rvalid  in  1  read data valid this cycle.
REQ-009 Port: imem_rdata  in  32  returned instruction word.
REQ-010 Port: if_valid  out  1  queue head holds a valid instruction.
REQ-011 Port: if_instr  out  32  queue head instruction; 32'h0 (nop) when if_valid=0.
REQ-012 Port: if_pc_next  out  32  queue head fetch address + 4, for the IF/ID pc_next register.
REQ-013 Port: if_ack  in  1  IF/ID write enable (hazard unit ifidWrite); pops head when if_valid=1.
REQ-014 Port: redirect  in  1  branch/jump taken; flush and refetch.
REQ-015 Port: redirect_addr  in  32  new fetch address, bits [1:0] ignored and forced to 0.

Function
REQ-016 Fetch PC register fpc drives imem_addr combinationally; imem_req = !outstanding & (count + outstanding < DEPTH) & !redirect.
REQ-017 imem_req and imem_addr remain stable until imem_gnt; on grant, fpc <= fpc + 4 (32-bit wrap) and outstanding <= 1.
REQ-018 At most one outstanding request; no new request in the cycle of the grant.
REQ-019 imem_rvalid with outstanding=1 and drop=0 pushes {imem_rdata, address+4} to the queue tail and clears outstanding; no other push path exists, so an entry becomes visible on if_valid one cycle after rvalid at the earliest.
REQ-020 Queue is FIFO ordered; if_instr/if_pc_next are registered head contents; pop occurs when if_valid & if_ack.
REQ-021 Simultaneous push and pop in the same cycle: count unchanged, both take effect.
REQ-022 Full: the rule in REQ-016 reserves a slot for the outstanding response, so a push never occurs when count = DEPTH; pointers wrap modulo DEPTH.
REQ-023 Empty: if_valid=0, if_instr=0; if_ack ignored.
REQ-024 Redirect (wins over all same-cycle events): fpc <= {redirect_addr[31:2],2'b00}; count, rd/wr pointers <= 0; same-cycle pop and push ignored; if_valid=0 next cycle.
REQ-025 Redirect while outstanding=1 and no same-cycle rvalid: drop <= 1; the next rvalid is discarded and clears outstanding and drop.
REQ-026 Redirect coinciding with rvalid: response discarded, outstanding <= 0, drop <= 0.
REQ-027 imem_rvalid while outstanding=0 is ignored.
REQ-028 First request to the new target is issued the cycle after redirect if no discard is pending, else the cycle after the discarded rvalid.

Reset
REQ-029 While rst_n=0 at a clock edge: fpc <= RESET_PC, count/pointers <= 0, outstanding <= 0, drop <= 0.
REQ-030 Outputs after reset: imem_req=1 (when redirect=0), imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_next=0.
REQ-031 Reset mid-transaction abandons any outstanding request; an rvalid in the first cycle after reset is ignored.

Verification
REQ-032 Reset, then imem_gnt next cycle, rvalid one cycle later returning 32'h2008_0005 -> if_valid=1, if_instr=32'h2008_0005, if_pc_next=32'h4.
REQ-033 if_ack=0 held, memory always grants/returns -> exactly 4 entries (pc_next 4,8,C,10), imem_req low once full; a single if_ack resumes fetch at 32'h10.
REQ-034 Queue holds 2 entries and a request is outstanding; redirect=1, redirect_addr=32'h0000_0043 -> if_valid=0 next cycle, the pending rvalid is discarded, the next request uses addr 32'h40, and the first delivered if_pc_next=32'h44.
REQ-035 Redirect in the same cycle as rvalid and if_ack=1 -> queue empty, count=0, response dropped, imem_req at 32'h target next cycle.
REQ-036 fpc=32'hFFFF_FFFC granted -> if_pc_next=32'h0, next imem_addr=32'h0 (wrap).
REQ-037 rst_n=0 asserted while outstanding=1 -> after release outputs match REQ-030; stale rvalid produces no queue entry.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a single outstanding memory request and a FIFO instruction queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_next,
    input  logic        if_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_addr
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] fpc_q, fpc_d;
    logic        out_q, out_d;
    logic        drop_q, drop_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pcn_q [DEPTH];
    logic        grant, resp, push, pop;

    // The fetch PC already points past the outstanding request, so it is that request's pc_next.
    assign imem_addr  = fpc_q;
    assign imem_req   = !out_q && (({1'b0, cnt_q} + (AW+2)'(out_q)) < (AW+2)'(DEPTH)) && !redirect;
    assign if_valid   = cnt_q != '0;
    assign if_instr   = if_valid ? instr_q[rd_q] : '0;
    assign if_pc_next = if_valid ? pcn_q[rd_q] : '0;
    assign grant      = imem_req & imem_gnt;
    assign resp       = imem_rvalid & out_q;
    assign push       = resp & !drop_q & !redirect;
    assign pop        = if_valid & if_ack & !redirect;

    // Next-state: redirect flushes the queue and overrides any same-cycle push, pop or grant.
    always_comb begin
        fpc_d  = redirect ? (redirect_addr & ~32'h3) : grant ? fpc_q + 32'd4 : fpc_q;
        out_d  = resp ? 1'b0 : grant ? 1'b1 : out_q;
        drop_d = resp ? 1'b0 : (redirect && out_q) ? 1'b1 : drop_q;
        cnt_d  = redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_d   = redirect ? '0 : rd_q + AW'(pop);
        wr_d   = redirect ? '0 : wr_q + AW'(push);
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q  <= RESET_PC;
            out_q  <= 1'b0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
        end else begin
            fpc_q  <= fpc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    // Queue storage; contents are only visible through a valid count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instr_q[wr_q] <= imem_rdata;
            pcn_q[wr_q]   <= fpc_q;
        end
    end
endmodule
